// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the multi-channel BRAM burst arbiter.
// Contents:
//   ch_w()            - width of a channel index for a given channel count
//   CH_W              - channel index width for the default channel count
//   bram_arb_state_t  - burst FSM state encoding
//   bram_arb_req_t    - one channel's burst request {we, addr, len}
package bram_arb_pkg;

    localparam int ARB_NUM_CH = 4;
    localparam int ARB_ADDR_W = 15;
    localparam int ARB_LEN_W  = 16;

    // A channel index always needs at least one bit, even for a single channel.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W = ch_w(ARB_NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_RD,
        S_WR,
        S_DRAIN,
        S_DONE
    } bram_arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_LEN_W-1:0]  len;
    } bram_arb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req       in  - request vector, one bit per channel
//   ptr       in  - index of the most recently granted channel
//   grant     out - one-hot grant (all zero when nothing requests)
//   grant_idx out - index of the granted channel
// The search starts at ptr+1 and wraps, so the last winner has lowest priority.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_CH = ARB_NUM_CH
) (
    input  logic [NUM_CH-1:0]       req,
    input  logic [ch_w(NUM_CH)-1:0] ptr,
    output logic [NUM_CH-1:0]       grant,
    output logic [ch_w(NUM_CH)-1:0] grant_idx
);

    localparam int CW = ch_w(NUM_CH);

    logic [CW-1:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CW'((int'(ptr) + i) % NUM_CH);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_burst_arbiter.sv
// Round-robin burst arbiter in front of one single-port BRAM.
// Ports:
//   clk, resetN                 - clock, synchronous active-low reset
//   abort                       - stop the running burst after the current beat
//   ch_req_valid/ready/we/addr/len - per-channel burst requests (ready pulses on grant)
//   ch_wdata/ch_wvalid/ch_wready   - per-channel write beat handshake
//   ch_done                     - one-cycle completion pulse per channel
//   rd_data/rd_valid/rd_ch      - shared read return stream, tagged by channel
//   busy                        - high whenever the FSM is not idle
//   bram_addr/wdata/en/we/rdata - BRAM port
// bram_rdata is expected RD_LATENCY-1 cycles after the read address; it is then
// registered here, so rd_valid appears RD_LATENCY cycles after the read enable.
module bram_burst_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_CH     = ARB_NUM_CH,
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = ARB_LEN_W,
    parameter int RD_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       abort,
    input  logic [NUM_CH-1:0]          ch_req_valid,
    output logic [NUM_CH-1:0]          ch_req_ready,
    input  logic [NUM_CH-1:0]          ch_req_we,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr,
    input  logic [NUM_CH*LEN_W-1:0]    ch_req_len,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    input  logic [NUM_CH-1:0]          ch_wvalid,
    output logic [NUM_CH-1:0]          ch_wready,
    output logic [NUM_CH-1:0]          ch_done,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [$clog2(NUM_CH)-1:0]  rd_ch,
    output logic                       busy,
    output logic [ADDR_W-1:0]          bram_addr,
    output logic [DATA_W-1:0]          bram_wdata,
    output logic                       bram_en,
    output logic                       bram_we,
    input  logic [DATA_W-1:0]          bram_rdata
);

    localparam int CW = ch_w(NUM_CH);

    bram_arb_state_t state_q, state_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cur_ch_q, cur_ch_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [RD_LATENCY-1:0] pipe_v_q, pipe_v_d;
    logic [CW-1:0]     pipe_ch_q [RD_LATENCY];
    logic [CW-1:0]     pipe_ch_d [RD_LATENCY];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic [NUM_CH-1:0] grant;
    logic [CW-1:0]     grant_idx;
    bram_arb_req_t     sel_req;
    logic [DATA_W-1:0] cur_wdata;
    logic              rd_issue;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req       (ch_req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Request fields of the winning channel, and write data of the owning channel.
    always_comb begin
        sel_req   = '0;
        cur_wdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                sel_req.we   = ch_req_we[c];
                sel_req.addr = ch_req_addr[c*ADDR_W +: ADDR_W];
                sel_req.len  = ch_req_len[c*LEN_W +: LEN_W];
            end
            if (cur_ch_q == CW'(c)) begin
                cur_wdata = ch_wdata[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cur_ch_d     = cur_ch_q;
        cur_addr_d   = cur_addr_q;
        rem_d        = rem_q;
        ch_req_ready = '0;
        ch_wready    = '0;
        ch_done      = '0;
        bram_en      = 1'b0;
        bram_we      = 1'b0;
        bram_addr    = cur_addr_q;
        bram_wdata   = '0;
        rd_issue     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|ch_req_valid) state_d = S_GRANT;
            end
            S_GRANT: begin
                // A request that vanished before the grant just returns to idle.
                if (|grant) begin
                    ch_req_ready = grant;
                    ptr_d        = grant_idx;
                    cur_ch_d     = grant_idx;
                    cur_addr_d   = sel_req.addr;
                    rem_d        = sel_req.len;
                    if (sel_req.len == '0)  state_d = S_DONE;
                    else if (sel_req.we)    state_d = S_WR;
                    else                    state_d = S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                bram_en    = 1'b1;
                rd_issue   = 1'b1;
                cur_addr_d = cur_addr_q + ADDR_W'(1);
                rem_d      = rem_q - LEN_W'(1);
                // The beat issued alongside abort still completes.
                if (abort || rem_q == LEN_W'(1)) state_d = S_DRAIN;
            end
            S_WR: begin
                ch_wready[cur_ch_q] = 1'b1;
                if (ch_wvalid[cur_ch_q]) begin
                    bram_en    = 1'b1;
                    bram_we    = 1'b1;
                    bram_wdata = cur_wdata;
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    rem_d      = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = S_DONE;
                end
                if (abort) state_d = S_DONE;
            end
            S_DRAIN: begin
                if (pipe_v_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                ch_done[cur_ch_q] = 1'b1;
                state_d           = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read-return pipeline: valid and channel tag travel alongside the BRAM access;
    // data is captured as the tag enters the last stage.
    always_comb begin
        pipe_v_d[0]  = rd_issue;
        pipe_ch_d[0] = cur_ch_q;
        for (int k = 1; k < RD_LATENCY; k++) begin
            pipe_v_d[k]  = pipe_v_q[k-1];
            pipe_ch_d[k] = pipe_ch_q[k-1];
        end
        rd_data_d = pipe_v_d[RD_LATENCY-1] ? bram_rdata : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            ptr_q      <= CW'(NUM_CH - 1);
            cur_ch_q   <= '0;
            cur_addr_q <= '0;
            rem_q      <= '0;
            pipe_v_q   <= '0;
            rd_data_q  <= '0;
            for (int k = 0; k < RD_LATENCY; k++) pipe_ch_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_ch_q   <= cur_ch_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            pipe_v_q   <= pipe_v_d;
            rd_data_q  <= rd_data_d;
            for (int k = 0; k < RD_LATENCY; k++) pipe_ch_q[k] <= pipe_ch_d[k];
        end
    end

    assign rd_valid = pipe_v_q[RD_LATENCY-1];
    assign rd_ch    = pipe_ch_q[RD_LATENCY-1];
    assign rd_data  = rd_data_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_bram_burst_arbiter.sv
// Scoreboard bench for bram_burst_arbiter: directed bursts push expected grants,
// BRAM accesses, read beats and done pulses; a negedge monitor pops and compares.
module tb_bram_burst_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int RD_LAT = 2;

    logic                      clk = 1'b0;
    logic                      resetN;
    logic                      abort;
    logic [NUM_CH-1:0]         ch_req_valid, ch_req_ready, ch_req_we;
    logic [NUM_CH*ADDR_W-1:0]  ch_req_addr;
    logic [NUM_CH*LEN_W-1:0]   ch_req_len;
    logic [NUM_CH*DATA_W-1:0]  ch_wdata;
    logic [NUM_CH-1:0]         ch_wvalid, ch_wready, ch_done;
    logic [DATA_W-1:0]         rd_data;
    logic                      rd_valid;
    logic [1:0]                rd_ch;
    logic                      busy;
    logic [ADDR_W-1:0]         bram_addr;
    logic [DATA_W-1:0]         bram_wdata, bram_rdata;
    logic                      bram_en, bram_we;

    bram_burst_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .LEN_W(LEN_W), .RD_LATENCY(RD_LAT)
    ) dut (
        .clk(clk), .resetN(resetN), .abort(abort),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
        .ch_req_we(ch_req_we), .ch_req_addr(ch_req_addr), .ch_req_len(ch_req_len),
        .ch_wdata(ch_wdata), .ch_wvalid(ch_wvalid), .ch_wready(ch_wready),
        .ch_done(ch_done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ch(rd_ch),
        .busy(busy), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_rdata(bram_rdata)
    );

    always #5 clk = ~clk;

    // BRAM model: one-cycle synchronous read, written data visible next cycle.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            else         bram_rdata     <= mem[bram_addr];
        end
    end

    typedef struct { int ch; logic [DATA_W-1:0] data; } rd_exp_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_exp_t;
    typedef struct { logic [DATA_W-1:0] data; int stall; } wbeat_t;

    rd_exp_t           exp_rd[$];
    logic [ADDR_W-1:0] exp_rd_addr[$];
    wr_exp_t           exp_wr[$];
    int                exp_grant[$];
    int                exp_done[$];
    int                issue_cyc[$];
    wbeat_t            wq[$];

    int tests_run = 0, tests_failed = 0;
    int cyc = 0;
    int wr_ch = 0, stall_cnt = 0;
    int abort_at_beat = 0, rd_beats_seen = 0;
    logic abort_mode = 1'b0;
    int en_rd_count, wr_count, done_count, grant_count, extra_rd;
    int grant_cyc, done_cyc;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every DUT event is compared against the head of its queue.
    always @(negedge clk) begin
        if (resetN) begin
            if (bram_we) checkOutput("we_without_en", {63'd0, bram_en}, 64'd1);
            if (bram_en && !bram_we) begin
                en_rd_count++;
                issue_cyc.push_back(cyc);
                if (exp_rd_addr.size() > 0) checkOutput("rd_addr", 64'(bram_addr), 64'(exp_rd_addr.pop_front()));
                else if (!abort_mode) checkOutput("rd_addr_unexpected", 64'd1, 64'd0);
            end
            if (bram_en && bram_we) begin
                wr_exp_t w;
                wr_count++;
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    checkOutput("wr_addr", 64'(bram_addr), 64'(w.addr));
                    checkOutput("wr_data", 64'(bram_wdata), 64'(w.data));
                end else checkOutput("wr_unexpected", 64'd1, 64'd0);
            end
            if (rd_valid) begin
                rd_exp_t e;
                if (issue_cyc.size() > 0) checkOutput("rd_latency", 64'(cyc - issue_cyc.pop_front()), 64'(RD_LAT));
                else checkOutput("rd_no_issue", 64'd1, 64'd0);
                if (exp_rd.size() > 0) begin
                    e = exp_rd.pop_front();
                    checkOutput("rd_ch", 64'(rd_ch), 64'(e.ch));
                    checkOutput("rd_data", 64'(rd_data), 64'(e.data));
                end else if (abort_mode) begin
                    extra_rd++;
                    checkOutput("abort_extra_data", 64'(rd_data), 64'h202);
                end else checkOutput("rd_unexpected", 64'd1, 64'd0);
            end
            if (|ch_req_ready) begin
                grant_count++;
                grant_cyc = cyc;
                if (exp_grant.size() > 0) checkOutput("grant", 64'(ch_req_ready), 64'(1 << exp_grant.pop_front()));
                else checkOutput("grant_unexpected", 64'(ch_req_ready), 64'd0);
            end
            if (|ch_done) begin
                done_count++;
                done_cyc = cyc;
                if (exp_done.size() > 0) checkOutput("done", 64'(ch_done), 64'(1 << exp_done.pop_front()));
                else checkOutput("done_unexpected", 64'(ch_done), 64'd0);
            end
        end
    end

    task automatic clearCounts();
        en_rd_count = 0; wr_count = 0; done_count = 0; grant_count = 0; extra_rd = 0;
        rd_beats_seen = 0;
    endtask

    task automatic applyStimulus(input int ch, input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [LEN_W-1:0] len, input logic expect_done);
        ch_req_we[ch]                     = we;
        ch_req_addr[ch*ADDR_W +: ADDR_W]  = addr;
        ch_req_len[ch*LEN_W +: LEN_W]     = len;
        ch_req_valid[ch]                  = 1'b1;
        exp_grant.push_back(ch);
        if (expect_done) exp_done.push_back(ch);
    endtask

    task automatic expectBeat(input int ch, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        rd_exp_t e;
        e.ch = ch; e.data = data;
        exp_rd.push_back(e);
        exp_rd_addr.push_back(addr);
    endtask

    task automatic expectWrite(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data, input int stall);
        wr_exp_t w;
        wbeat_t  b;
        w.addr = addr; w.data = data;
        exp_wr.push_back(w);
        b.data = data; b.stall = stall;
        if (wq.size() == 0) stall_cnt = stall;
        wq.push_back(b);
    endtask

    // One clock: retire granted requests and accepted write beats, drive next beat, abort.
    task automatic stepCycle();
        logic [NUM_CH-1:0] rdy, hs;
        @(negedge clk);
        rdy = ch_req_ready;
        hs  = ch_wvalid & ch_wready;
        @(posedge clk); #1;
        ch_req_valid = ch_req_valid & ~rdy;
        if (hs[wr_ch] && wq.size() > 0) begin
            void'(wq.pop_front());
            stall_cnt = (wq.size() > 0) ? wq[0].stall : 0;
        end
        ch_wvalid = '0;
        if (wq.size() > 0) begin
            if (stall_cnt > 0) stall_cnt--;
            else begin
                ch_wvalid[wr_ch] = 1'b1;
                ch_wdata[wr_ch*DATA_W +: DATA_W] = wq[0].data;
            end
        end
        if (bram_en && !bram_we) rd_beats_seen++;
        abort = (abort_at_beat > 0) && bram_en && !bram_we && (rd_beats_seen == abort_at_beat);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        do begin
            stepCycle();
            n++;
        end while (!(!busy && ch_req_valid == '0 && wq.size() == 0) && n < budget);
        checkOutput("idle_timeout", 64'(n < budget), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i);
        bram_rdata = '0;
        resetN = 1'b0; abort = 1'b0;
        ch_req_valid = '0; ch_req_we = '0; ch_req_addr = '0; ch_req_len = '0;
        ch_wdata = '0; ch_wvalid = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy",      64'(busy), 64'd0);
        checkOutput("rst_rd_valid",  64'(rd_valid), 64'd0);
        checkOutput("rst_rd_ch",     64'(rd_ch), 64'd0);
        checkOutput("rst_rd_data",   64'(rd_data), 64'd0);
        checkOutput("rst_bram_en",   64'({bram_en, bram_we}), 64'd0);
        checkOutput("rst_handshake", 64'({ch_req_ready, ch_wready, ch_done}), 64'd0);
        resetN = 1'b1;
        stepCycle();

        // Round robin from ptr=3: grants 0,1,2,3, two beats each.
        clearCounts();
        for (int c = 0; c < NUM_CH; c++) begin
            applyStimulus(c, 1'b0, ADDR_W'(c * 'h40), LEN_W'(2), 1'b1);
            expectBeat(c, ADDR_W'(c * 'h40),     DATA_W'(c * 'h40));
            expectBeat(c, ADDR_W'(c * 'h40 + 1), DATA_W'(c * 'h40 + 1));
        end
        waitIdle(200);
        checkOutput("rr_grant_count", 64'(grant_count), 64'd4);
        checkOutput("rr_done_count",  64'(done_count), 64'd4);

        // Single read ch1, 0x10 len 4.
        clearCounts();
        applyStimulus(1, 1'b0, 15'h0010, 16'd4, 1'b1);
        for (int i = 0; i < 4; i++) expectBeat(1, ADDR_W'('h10 + i), DATA_W'('h10 + i));
        waitIdle(100);
        checkOutput("rd1_en_cycles", 64'(en_rd_count), 64'd4);
        checkOutput("rd1_done_count", 64'(done_count), 64'd1);

        // Write ch2 with a two-cycle stall before the second beat, then read back.
        clearCounts();
        wr_ch = 2;
        expectWrite(15'h0100, 32'hA0A0_0001, 0);
        expectWrite(15'h0101, 32'hB0B0_0002, 2);
        expectWrite(15'h0102, 32'hC0C0_0003, 0);
        applyStimulus(2, 1'b1, 15'h0100, 16'd3, 1'b1);
        waitIdle(100);
        checkOutput("wr_we_cycles", 64'(wr_count), 64'd3);
        applyStimulus(2, 1'b0, 15'h0100, 16'd3, 1'b1);
        expectBeat(2, 15'h0100, 32'hA0A0_0001);
        expectBeat(2, 15'h0101, 32'hB0B0_0002);
        expectBeat(2, 15'h0102, 32'hC0C0_0003);
        waitIdle(100);

        // Address wrap at the top of the BRAM.
        applyStimulus(0, 1'b0, 15'h7FFE, 16'd4, 1'b1);
        expectBeat(0, 15'h7FFE, 32'h7FFE);
        expectBeat(0, 15'h7FFF, 32'h7FFF);
        expectBeat(0, 15'h0000, 32'h0000);
        expectBeat(0, 15'h0001, 32'h0001);
        waitIdle(100);

        // Abort during beat 2 of a len-8 read: two beats certain, at most one more.
        clearCounts();
        abort_mode = 1'b1;
        abort_at_beat = 2;
        applyStimulus(3, 1'b0, 15'h0200, 16'd8, 1'b1);
        expectBeat(3, 15'h0200, 32'h0200);
        expectBeat(3, 15'h0201, 32'h0201);
        waitIdle(100);
        abort_at_beat = 0;
        abort = 1'b0;
        abort_mode = 1'b0;
        checkOutput("abort_extra_le1", 64'(extra_rd <= 1), 64'd1);
        checkOutput("abort_done", 64'(done_count), 64'd1);
        checkOutput("abort_busy", 64'(busy), 64'd0);

        // Zero-length request: grant, done one cycle later, no BRAM access.
        clearCounts();
        applyStimulus(1, 1'b0, 15'h0050, 16'd0, 1'b1);
        waitIdle(50);
        checkOutput("zero_len_gap", 64'(done_cyc - grant_cyc), 64'd1);
        checkOutput("zero_len_no_bram", 64'(en_rd_count + wr_count), 64'd0);

        // Reset in the middle of a stalled write burst.
        clearCounts();
        wr_ch = 3;
        expectWrite(15'h0300, 32'hD0D0_0000, 0);
        begin
            wbeat_t b;
            b.data = 32'hD0D0_0001; b.stall = 100;
            wq.push_back(b);
        end
        applyStimulus(3, 1'b1, 15'h0300, 16'd4, 1'b0);
        for (int n = 0; n < 20 && wq.size() > 1; n++) stepCycle();
        stepCycle();
        checkOutput("rst_mid_in_wr", 64'(ch_wready), 64'h8);
        resetN = 1'b0;
        @(posedge clk); #1;
        wq.delete();
        ch_wvalid = '0;
        ch_req_valid = '0;
        checkOutput("rst_mid_busy",   64'(busy), 64'd0);
        checkOutput("rst_mid_bram",   64'({bram_en, bram_we}), 64'd0);
        checkOutput("rst_mid_hs",     64'({ch_req_ready, ch_wready, ch_done}), 64'd0);
        checkOutput("rst_mid_rvalid", 64'(rd_valid), 64'd0);
        @(posedge clk); #1;
        resetN = 1'b1;
        checkOutput("rst_mid_no_done", 64'(done_count), 64'd0);
        applyStimulus(3, 1'b0, 15'h0300, 16'd1, 1'b1);
        expectBeat(3, 15'h0300, 32'hD0D0_0000);
        waitIdle(100);

        checkOutput("left_rd",    64'(exp_rd.size() + exp_rd_addr.size()), 64'd0);
        checkOutput("left_wr",    64'(exp_wr.size()), 64'd0);
        checkOutput("left_grant", 64'(exp_grant.size()), 64'd0);
        checkOutput("left_done",  64'(exp_done.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
